fredetect_scheduler: RTL and testbench
======================================

Name: fredetect_scheduler

Overview:
Sequencer that shares one period/frequency measurement datapath between N_CH asynchronous test inputs.
- Selects channels round-robin and synchronizes the selected input.
- Opens a fixed gate window of GATE_CYCLES reference-clock cycles and counts rising edges of the selected input.
- Reports one result per channel, in one-shot sweep or continuous mode.
- Sits between the raw test lines and the readout/register logic of the synchronization block.

Parameters:
N_CH, 4, number of test input channels (2..16)
GATE_CYCLES, 1000, gate window length in clk cycles (>=2)
CNT_W, 16, edge-count result width
SETTLE, 4, clk cycles discarded after each channel switch (synchronizer flush, >=2)

Ports:
clk  input  1  reference clock
rst  input  1  synchronous reset
start  input  1  single-cycle request to begin a sweep
continuous  input  1  1 = restart the sweep automatically after the last enabled channel
ch_enable  input  N_CH  per-channel enable mask
test  input  N_CH  asynchronous test signals
busy  output  1  high from the cycle after an accepted start until return to IDLE
sel  output  clog2(N_CH)  channel currently being measured
res_valid  output  1  one-cycle pulse, result fields valid
res_ch  output  clog2(N_CH)  channel of the result
res_count  output  CNT_W  rising edges counted in the gate window
res_ovf  output  1  count saturated during the window
done  output  1  one-cycle pulse at the end of a one-shot sweep

Behaviour:
Reset and clocking
- One clock, clk. Reset is synchronous and active-high on rst.
- On rst: state=IDLE; busy, res_valid, done, res_ovf = 0; sel, res_ch, res_count = 0; synchronizers and counters cleared.
- rst mid-operation aborts the window with no res_valid and no done.

Input conditioning
- Every test bit passes through a 2-FF synchronizer.
- The selected bit drives a rising-edge detector: sync_now=1 and sync_prev=0.

State machine: IDLE, PICK, SETTLE, GATE, REPORT
- IDLE: start=1 and ch_enable!=0 -> PICK; the round-robin pointer resets so that channel 0 is examined first. start with ch_enable==0 is ignored and state stays IDLE. start is ignored in every other state.
- PICK (1 cycle):
  - Choose the lowest enabled channel >= pointer; ch_enable is sampled here only. Set sel. Go to SETTLE.
  - If no enabled channel remains in this sweep: if continuous=1, wrap the pointer to 0 and pick again; otherwise pulse done and go to IDLE.
  - If continuous=1 and ch_enable becomes 0, go to IDLE without done.
- SETTLE: exactly SETTLE cycles. Edge detector is held cleared so no edge is counted across the switch. Then go to GATE.
- GATE: exactly GATE_CYCLES cycles. Each detected edge increments the count. The count saturates at 2^CNT_W-1 and sets ovf sticky for the window. An edge in the first GATE cycle counts; an edge in the cycle after the last does not.
- REPORT (1 cycle): res_valid=1; res_ch, res_count, res_ovf update and then hold until the next REPORT. Pointer = sel+1. Go to PICK.

Sweep and mode rules
- continuous sampled 0 at PICK ends the sweep at the current position: finish the active window, then done at the next PICK with no remaining channel.
- A channel whose enable clears mid-window still completes and reports.
- busy=1 in PICK, SETTLE, GATE, REPORT, and 0 in IDLE.

Latency
- start at cycle t gives the first res_valid at cycle t+2+SETTLE+GATE_CYCLES.
- Each further channel adds 2+SETTLE+GATE_CYCLES cycles.

Decomposition:
- fredetect_pkg:
  - state enum {IDLE, PICK, SETTLE, GATE, REPORT}
  - clog2-based CHW width constant/function
  - saturating-max constant helper
- Sub-module fredetect_edge_counter: synchronizer-fed edge detect, clear, enable, saturating CNT_W counter, ovf flag.
- Mux, round-robin pointer and FSM stay in fredetect_scheduler.

Test Plan:
1. ch_enable=4'b0001; test[0] toggles every 10 clk cycles (period 20); start once, continuous=0 -> one res_valid at t+1006 with res_ch=0, res_count=50 (±1) and res_ovf=0, then done next-next cycle and busy=0.
2. ch_enable=4'b1010 with periods 20/40 on ch1/ch3; one-shot -> two results in order ch1 then ch3, counts 50 and 25 (±1), exactly one done, ch0/ch2 never selected.
3. continuous=1, ch_enable=4'b0011 -> results alternate ch0, ch1, ch0, ... every 1006 cycles. Drop continuous during the ch0 window -> that result is still reported, ch1 is not measured, done follows, busy falls.
4. CNT_W=4, test toggling every clk -> res_count=15 and res_ovf=1; the next window on a slow channel reports res_ovf=0.
5. start with ch_enable=0 -> busy stays 0, no res_valid. start pulses while busy -> no effect on sequence or timing.
6. Assert rst for 1 cycle mid-GATE -> next cycle all outputs at reset values, no res_valid or done. A new start then reproduces scenario 1 timing exactly.

Source files
------------

// File: rtl/fredetect_pkg.sv
// Shared state encoding and constant helpers for the frequency-detect scheduler.
package fredetect_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_SETTLE,
    S_GATE,
    S_REPORT
  } state_t;

  // Channel-index width; never narrower than one bit.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sat_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/fredetect_edge_counter.sv
// Rising-edge detector on an already synchronized line feeding a saturating gated counter.
module fredetect_edge_counter
  import fredetect_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic             prev;
  logic             edge_det;
  logic [CNT_W-1:0] count;
  logic             ovf;

  // prev keeps tracking while cleared, so a line that is already high at the
  // start of the window is not mistaken for an edge.
  assign edge_det = en & sig_in & ~prev;

  always_comb begin
    cnt_next = count;
    ovf_next = ovf;
    if (edge_det) begin
      if (count == CNT_MAX) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      prev <= sig_in;
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        count <= cnt_next;
        ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: rtl/fredetect_scheduler.sv
// Round-robin sequencer sharing one gated edge counter between N_CH asynchronous test lines.
module fredetect_scheduler
  import fredetect_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [N_CH-1:0]      ch_enable,
  input  logic [N_CH-1:0]      test,
  output logic                 busy,
  output logic [chw(N_CH)-1:0] sel,
  output logic                 res_valid,
  output logic [chw(N_CH)-1:0] res_ch,
  output logic [CNT_W-1:0]     res_count,
  output logic                 res_ovf,
  output logic                 done
);

  localparam int CHW  = chw(N_CH);
  localparam int PW   = CHW + 1;
  localparam int TMAX = (GATE_CYCLES > SETTLE) ? GATE_CYCLES : SETTLE;
  localparam int TW   = $clog2(TMAX) + 1;

  state_t           state;
  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [PW-1:0]    ptr;
  logic [TW-1:0]    timer;
  logic             cont_mode;
  logic             found_hi;
  logic             found_lo;
  logic [CHW-1:0]   idx_hi;
  logic [CHW-1:0]   idx_lo;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= test;
      sync2 <= sync1;
    end
  end

  fredetect_edge_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sync2[sel]),
    .clr      (state != S_GATE),
    .en       (state == S_GATE),
    .cnt_next (cnt_next),
    .ovf_next (ovf_next)
  );

  // Descending scan so the last hit is the lowest index; lo ignores the pointer for wrap-around.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) begin
        found_lo = 1'b1;
        idx_lo   = CHW'(i);
        if (PW'(i) >= ptr) begin
          found_hi = 1'b1;
          idx_hi   = CHW'(i);
        end
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      ptr       <= '0;
      timer     <= '0;
      cont_mode <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_count <= '0;
      res_ovf   <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (ch_enable != '0)) begin
            ptr       <= '0;
            cont_mode <= continuous;
            state     <= S_PICK;
          end
        end
        S_PICK: begin
          timer     <= '0;
          cont_mode <= continuous;
          // Leaving continuous mode ends the sweep right after the window that just reported.
          if (cont_mode && !continuous) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (found_hi) begin
            sel   <= idx_hi;
            state <= S_SETTLE;
          end else if (continuous && found_lo) begin
            sel   <= idx_lo;
            state <= S_SETTLE;
          end else if (continuous) begin
            state <= S_IDLE;
          end else begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (timer == TW'(SETTLE - 1)) begin
            timer <= '0;
            state <= S_GATE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GATE: begin
          if (timer == TW'(GATE_CYCLES - 1)) begin
            res_valid <= 1'b1;
            res_ch    <= sel;
            res_count <= cnt_next;
            res_ovf   <= ovf_next;
            state     <= S_REPORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_REPORT: begin
          ptr   <= PW'(sel) + PW'(1);
          state <= S_PICK;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fredetect_scheduler.sv
// Directed scenarios for fredetect_scheduler with hand-computed counts and latencies.
module tb_fredetect_scheduler;

  localparam int GATE = 1000;
  localparam int SETL = 4;
  localparam int LAT  = 2 + SETL + GATE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [3:0]  ch_enable = '0;
  logic [3:0]  test;
  logic        busy;
  logic [1:0]  sel;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [15:0] res_count;
  logic        res_ovf;
  logic        done;

  logic        start4 = 1'b0;
  logic [3:0]  ch_enable4 = '0;
  logic [3:0]  test4;
  logic        busy4;
  logic [1:0]  sel4;
  logic        res_valid4;
  logic [1:0]  res_ch4;
  logic [3:0]  res_count4;
  logic        res_ovf4;
  logic        done4;

  int n_checks = 0;
  int n_fail = 0;
  int half[4] = '{default: 0};
  int tcnt[4] = '{default: 0};
  int tcnt4 = 0;

  fredetect_scheduler #(
    .N_CH(4), .GATE_CYCLES(GATE), .CNT_W(16), .SETTLE(SETL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .ch_enable(ch_enable), .test(test), .busy(busy), .sel(sel),
    .res_valid(res_valid), .res_ch(res_ch), .res_count(res_count),
    .res_ovf(res_ovf), .done(done)
  );

  fredetect_scheduler #(
    .N_CH(4), .GATE_CYCLES(GATE), .CNT_W(4), .SETTLE(SETL)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .continuous(1'b0),
    .ch_enable(ch_enable4), .test(test4), .busy(busy4), .sel(sel4),
    .res_valid(res_valid4), .res_ch(res_ch4), .res_count(res_count4),
    .res_ovf(res_ovf4), .done(done4)
  );

  always #5 clk = ~clk;

  // Test lines change on the falling edge; dut4 ch0 toggles every cycle, ch1 every 50.
  initial begin
    test  = '0;
    test4 = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (half[c] != 0) begin
          tcnt[c]++;
          if (tcnt[c] >= half[c]) begin
            tcnt[c] = 0;
            test[c] = ~test[c];
          end
        end
      end
      test4[0] = ~test4[0];
      tcnt4++;
      if (tcnt4 >= 50) begin
        tcnt4 = 0;
        test4[1] = ~test4[1];
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic cont);
    ch_enable  = en;
    continuous = cont;
    start      = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end while (!res_valid && cycles < budget);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    n_checks++;
    if ({busy, sel, res_valid, res_ch, res_count, res_ovf, done} !== 23'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut: outputs %h, expected 0", {busy, sel, res_valid, res_ch, res_count, res_ovf, done});
    end
    n_checks++;
    if ({busy4, sel4, res_valid4, res_ch4, res_count4, res_ovf4, done4} !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut4: outputs %h, expected 0", {busy4, sel4, res_valid4, res_ch4, res_count4, res_ovf4, done4});
    end
  endtask

  task automatic test_single();
    int c;
    half[0] = 10;
    applyStimulus(4'b0001, 1'b0);
    wait_valid(LAT + 20, c);
    n_checks++;
    if (c !== LAT) begin n_fail++; $display("[TB] FAIL single_latency: got %0d, expected %0d", c, LAT); end
    n_checks++;
    if (res_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL single_ch: got %0d, expected 0", res_ch); end
    n_checks++;
    if (res_count < 49 || res_count > 51) begin n_fail++; $display("[TB] FAIL single_count: got %0d, expected 49..51", res_count); end
    n_checks++;
    if (res_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL single_ovf: got %b, expected 0", res_ovf); end
    step(1);
    n_checks++;
    if ({done, busy, res_valid} !== 3'b010) begin n_fail++; $display("[TB] FAIL single_pick: done/busy/valid %b, expected 010", {done, busy, res_valid}); end
    step(1);
    n_checks++;
    if ({done, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL single_done: done/busy %b, expected 10", {done, busy}); end
    step(1);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL single_done_pulse: got %b, expected 0", done); end
  endtask

  task automatic test_two_channels();
    int c;
    int nd;
    int nv;
    half = '{0, 10, 0, 20};
    applyStimulus(4'b1010, 1'b0);
    step(500);
    n_checks++;
    if (sel !== 2'd1) begin n_fail++; $display("[TB] FAIL two_sel_a: got %0d, expected 1", sel); end
    wait_valid(LAT, c);
    n_checks++;
    if (c !== LAT - 500 || res_ch !== 2'd1) begin n_fail++; $display("[TB] FAIL two_first: cycles %0d ch %0d, expected %0d ch 1", c, res_ch, LAT - 500); end
    n_checks++;
    if (res_count < 49 || res_count > 51) begin n_fail++; $display("[TB] FAIL two_count_a: got %0d, expected 49..51", res_count); end
    step(500);
    n_checks++;
    if (sel !== 2'd3) begin n_fail++; $display("[TB] FAIL two_sel_b: got %0d, expected 3", sel); end
    wait_valid(LAT, c);
    n_checks++;
    if (c !== LAT - 500 || res_ch !== 2'd3) begin n_fail++; $display("[TB] FAIL two_second: cycles %0d ch %0d, expected %0d ch 3", c, res_ch, LAT - 500); end
    n_checks++;
    if (res_count < 24 || res_count > 26) begin n_fail++; $display("[TB] FAIL two_count_b: got %0d, expected 24..26", res_count); end
    nd = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      nd += int'(done);
      nv += int'(res_valid);
    end
    n_checks++;
    if (nd !== 1 || nv !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL two_end: done %0d valid %0d busy %b, expected 1 0 0", nd, nv, busy); end
  endtask

  task automatic test_continuous();
    int c;
    int nd;
    int nv;
    half = '{10, 20, 0, 0};
    applyStimulus(4'b0011, 1'b1);
    wait_valid(LAT + 20, c);
    n_checks++;
    if (c !== LAT || res_ch !== 2'd0 || res_count < 49 || res_count > 51) begin
      n_fail++; $display("[TB] FAIL cont_r1: cycles %0d ch %0d count %0d, expected %0d ch 0 count 49..51", c, res_ch, res_count, LAT);
    end
    wait_valid(LAT + 20, c);
    n_checks++;
    if (c !== LAT || res_ch !== 2'd1 || res_count < 24 || res_count > 26) begin
      n_fail++; $display("[TB] FAIL cont_r2: cycles %0d ch %0d count %0d, expected %0d ch 1 count 24..26", c, res_ch, res_count, LAT);
    end
    step(500);
    continuous = 1'b0;
    wait_valid(LAT, c);
    n_checks++;
    if (c !== LAT - 500 || res_ch !== 2'd0) begin n_fail++; $display("[TB] FAIL cont_r3: cycles %0d ch %0d, expected %0d ch 0", c, res_ch, LAT - 500); end
    nd = 0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      nd += int'(done);
      nv += int'(res_valid);
    end
    n_checks++;
    if (nd !== 1 || nv !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_stop: done %0d valid %0d busy %b, expected 1 0 0", nd, nv, busy); end
  endtask

  task automatic test_saturation();
    int c;
    ch_enable  = '0;
    ch_enable4 = 4'b0011;
    start4     = 1'b1;
    c = 0;
    do begin @(posedge clk); #1; start4 = 1'b0; c++; end while (!res_valid4 && c < LAT + 20);
    n_checks++;
    if (c !== LAT || res_ch4 !== 2'd0) begin n_fail++; $display("[TB] FAIL sat_r1: cycles %0d ch %0d, expected %0d ch 0", c, res_ch4, LAT); end
    n_checks++;
    if (res_count4 !== 4'd15 || res_ovf4 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_count: count %0d ovf %b, expected 15 1", res_count4, res_ovf4); end
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!res_valid4 && c < LAT + 20);
    n_checks++;
    if (c !== LAT || res_ch4 !== 2'd1) begin n_fail++; $display("[TB] FAIL sat_r2: cycles %0d ch %0d, expected %0d ch 1", c, res_ch4, LAT); end
    n_checks++;
    if (res_count4 < 9 || res_count4 > 11 || res_ovf4 !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_slow: count %0d ovf %b, expected 9..11 0", res_count4, res_ovf4); end
    step(2);
    n_checks++;
    if ({done4, busy4} !== 2'b10) begin n_fail++; $display("[TB] FAIL sat_done: done/busy %b, expected 10", {done4, busy4}); end
    ch_enable4 = '0;
  endtask

  task automatic test_ignored_start();
    int c;
    int nb;
    int nv;
    half = '{10, 0, 0, 0};
    applyStimulus(4'b0000, 1'b0);
    nb = 0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      nb += int'(busy);
      nv += int'(res_valid);
    end
    n_checks++;
    if (nb !== 0 || nv !== 0) begin n_fail++; $display("[TB] FAIL empty_start: busy %0d valid %0d, expected 0 0", nb, nv); end
    applyStimulus(4'b0001, 1'b0);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
      start = (c == 300 || c == LAT - 1 || c == LAT);
    end while (!res_valid && c < LAT + 20);
    n_checks++;
    if (c !== LAT || res_ch !== 2'd0 || res_count < 49 || res_count > 51) begin
      n_fail++; $display("[TB] FAIL busy_start: cycles %0d ch %0d count %0d, expected %0d ch 0 count 49..51", c, res_ch, res_count, LAT);
    end
    step(2);
    n_checks++;
    if ({done, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL busy_start_done: done/busy %b, expected 10", {done, busy}); end
    step(3);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_start_idle: busy %b, expected 0", busy); end
  endtask

  task automatic test_reset_mid_gate();
    int c;
    int nd;
    int nv;
    applyStimulus(4'b0001, 1'b0);
    step(500);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if ({busy, sel, res_valid, res_ch, res_count, res_ovf, done} !== 23'd0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: %h, expected 0", {busy, sel, res_valid, res_ch, res_count, res_ovf, done});
    end
    nd = 0;
    nv = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1);
      nd += int'(done);
      nv += int'(res_valid);
    end
    n_checks++;
    if (nd !== 0 || nv !== 0) begin n_fail++; $display("[TB] FAIL midreset_quiet: done %0d valid %0d, expected 0 0", nd, nv); end
    applyStimulus(4'b0001, 1'b0);
    wait_valid(LAT + 20, c);
    n_checks++;
    if (c !== LAT || res_ch !== 2'd0 || res_count < 49 || res_count > 51) begin
      n_fail++; $display("[TB] FAIL midreset_rerun: cycles %0d ch %0d count %0d, expected %0d ch 0 count 49..51", c, res_ch, res_count, LAT);
    end
    step(2);
    n_checks++;
    if ({done, busy} !== 2'b10) begin n_fail++; $display("[TB] FAIL midreset_done: done/busy %b, expected 10", {done, busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_channels();
    test_continuous();
    test_saturation();
    test_ignored_start();
    test_reset_mid_gate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
